genclkdiv_frmsync: RTL and testbench

Parametrised successor to the fixed divide-by-4 frame-aligned clock generator. It divides iclk by a runtime-programmable ratio and produces a registered divided clock plus a one-cycle enable. The output phase is aligned to a frame sync, with a hunt/lock flywheel, so isolated bad syncs do not disturb a locked output. It sits beside framers and line-side blocks that need sub-rate clocks or enables locked to the frame.

---
 rtl/genclkdiv_frmsync_if.sv | 30 +++
 rtl/genclkdiv_frmsync.sv | 139 +++++++++++++
 tb/tb_genclkdiv_frmsync.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/genclkdiv_frmsync_if.sv
// Control and output bundle of the frame-aligned programmable clock divider.
// The master drives the ratio and frame sync; the slave returns the divided clock and status.
interface genclkdiv_frmsync_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] div;
    logic             frmsync;
    logic             oclk;
    logic             oce;
    logic             locked;
    logic             slip;

    modport master (
        output div,
        output frmsync,
        input  oclk,
        input  oce,
        input  locked,
        input  slip
    );

    modport slave (
        input  div,
        input  frmsync,
        output oclk,
        output oce,
        output locked,
        output slip
    );
endinterface

// File: rtl/genclkdiv_frmsync.sv
// Runtime-programmable clock divider whose phase follows a frame sync through a
// hunt/check/locked flywheel, so that isolated bad syncs leave a locked output alone.
module genclkdiv_frmsync #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3,
    parameter int MISS_N = 2
) (
    input  logic                 iclk,
    input  logic                 rst,
    genclkdiv_frmsync_if.slave   bus
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_N);
    localparam logic [3:0] MISS_LIM = 4'(MISS_N);

    state_t           state;
    state_t           state_next;
    logic [3:0]       good;
    logic [3:0]       good_next;
    logic [3:0]       miss;
    logic [3:0]       miss_next;
    logic             realign;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] rdiv;
    logic [CNT_W-1:0] rdiv_next;
    logic             frmsync_d;
    logic             sedge;
    logic             aligned;
    logic             wrap;
    logic             oclk_next;
    logic             oce_next;

    // A ratio of 1 cannot be produced, so div=0 runs at ratio 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // High for the first ceil(ratio/2) counts, i.e. while cnt <= rdiv/2.
    function automatic logic high_phase(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] r);
        return (c <= (r >> 1));
    endfunction

    assign sedge   = bus.frmsync & ~frmsync_d;
    assign aligned = (cnt == rdiv);
    assign wrap    = (cnt >= rdiv);

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            good  <= '0;
            miss  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
            miss  <= miss_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good;
        miss_next  = miss;
        realign    = 1'b0;
        if (sedge) begin
            case (state)
                HUNT: begin
                    realign    = 1'b1;
                    good_next  = '0;
                    miss_next  = '0;
                    state_next = CHECK;
                end
                CHECK: begin
                    if (aligned) begin
                        good_next = good + 4'd1;
                        if ((good + 4'd1) == LOCK_LIM) begin
                            state_next = LOCKED;
                            miss_next  = '0;
                        end
                    end else begin
                        realign   = 1'b1;
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        miss_next = '0;
                    end else if ((miss + 4'd1) == MISS_LIM) begin
                        // Flywheel exhausted: re-phase on this very edge.
                        realign    = 1'b1;
                        state_next = CHECK;
                        good_next  = '0;
                        miss_next  = '0;
                    end else begin
                        miss_next = miss + 4'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // A new ratio only takes effect at a period boundary (wrap or realign).
    always_comb begin
        cnt_next  = cnt + CNT_W'(1);
        rdiv_next = rdiv;
        if (realign || wrap) begin
            cnt_next  = '0;
            rdiv_next = clamp_div(bus.div);
        end
        oclk_next = high_phase(cnt_next, rdiv_next);
        oce_next  = (cnt_next == '0);
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rdiv       <= CNT_W'(1);
            frmsync_d  <= 1'b0;
            bus.oclk   <= 1'b0;
            bus.oce    <= 1'b0;
            bus.locked <= 1'b0;
            bus.slip   <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            rdiv       <= rdiv_next;
            frmsync_d  <= bus.frmsync;
            bus.oclk   <= oclk_next;
            bus.oce    <= oce_next;
            bus.locked <= (state_next == LOCKED);
            bus.slip   <= realign;
        end
    end

endmodule

// File: tb/tb_genclkdiv_frmsync.sv
// Directed bench for genclkdiv_frmsync: a vector table for free-running division,
// then hand-built sync sequences for locking, flywheel, realign, reset and ratio change.
module tb_genclkdiv_frmsync;

    logic iclk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    logic slip_seen;

    genclkdiv_frmsync_if #(.CNT_W(8)) bus ();

    genclkdiv_frmsync #(.CNT_W(8), .LOCK_N(3), .MISS_N(2)) dut (
        .iclk (iclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic       rst;
        logic [7:0] div;
        logic       fs;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [13];

    // Outputs packed as {oclk, oce, locked, slip}.
    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %b expected %b (oclk,oce,locked,slip)", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_out(input string name, input logic [3:0] exp);
        check(name, {bus.oclk, bus.oce, bus.locked, bus.slip}, exp);
    endtask

    task automatic tick(input logic fs);
        bus.frmsync = fs;
        @(posedge iclk);
        #1;
        slip_seen = slip_seen | bus.slip;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) tick(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        bus.div     = 8'd4;
        bus.frmsync = 1'b0;
        slip_seen   = 1'b0;

        // Ratio 5 free-running from reset: the reset ratio 2 governs the first period.
        vecs[0]  = '{1'b1, 8'd4, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 8'd4, 1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 8'd4, 1'b0, 4'b1100};
        vecs[3]  = '{1'b0, 8'd4, 1'b0, 4'b1000};
        vecs[4]  = '{1'b0, 8'd4, 1'b0, 4'b1000};
        vecs[5]  = '{1'b0, 8'd4, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 8'd4, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 8'd4, 1'b0, 4'b1100};
        vecs[8]  = '{1'b0, 8'd4, 1'b0, 4'b1000};
        vecs[9]  = '{1'b0, 8'd4, 1'b0, 4'b1000};
        vecs[10] = '{1'b0, 8'd4, 1'b0, 4'b0000};
        vecs[11] = '{1'b0, 8'd4, 1'b0, 4'b0000};
        vecs[12] = '{1'b0, 8'd4, 1'b0, 4'b1100};

        for (int i = 0; i < 13; i++) begin
            rst         = vecs[i].rst;
            bus.div     = vecs[i].div;
            bus.frmsync = vecs[i].fs;
            @(posedge iclk);
            #1;
            check($sformatf("ratio5_vec%0d", i), {bus.oclk, bus.oce, bus.locked, bus.slip},
                  vecs[i].exp);
        end

        // Acquire at div=3 with a sync every 16 cycles.
        rst     = 1'b1;
        bus.div = 8'd3;
        @(posedge iclk);
        #1;
        rst = 1'b0;
        gap(5);
        tick(1'b1);  check_out("acq_first_edge", 4'b1101);
        slip_seen = 1'b0;
        tick(1'b0);  check_out("acq_cnt1", 4'b1000);
        tick(1'b0);  check_out("acq_cnt2", 4'b0000);
        tick(1'b0);  check_out("acq_cnt3", 4'b0000);
        tick(1'b0);  check_out("acq_cnt0", 4'b1100);
        gap(11);
        tick(1'b1);  check_out("acq_edge2", 4'b1100);
        gap(15);
        tick(1'b1);  check_out("acq_edge3", 4'b1100);
        gap(14);
        tick(1'b0);  check_out("acq_prelock", 4'b0000);
        tick(1'b1);  check_out("acq_lock", 4'b1110);

        // Single early edge is absorbed; the next aligned edge clears the miss count.
        gap(13);
        tick(1'b1);  check_out("fly_early1", 4'b0010);
        tick(1'b0);
        tick(1'b1);  check_out("fly_aligned1", 4'b1110);
        gap(13);
        tick(1'b1);  check_out("fly_early2", 4'b0010);
        tick(1'b0);
        tick(1'b1);  check_out("fly_aligned2", 4'b1110);
        check("no_slip_while_locked", {3'b000, slip_seen}, 4'b0000);

        // Two consecutive misplaced edges force a realign, then relock.
        gap(13);
        tick(1'b1);  check_out("miss1", 4'b0010);
        gap(6);
        tick(1'b1);  check_out("miss2_realign", 4'b1101);
        tick(1'b0);  check_out("realign_cnt1", 4'b1000);
        gap(14);
        tick(1'b1);  check_out("relock_edge1", 4'b1100);
        gap(15);
        tick(1'b1);  check_out("relock_edge2", 4'b1100);
        gap(15);
        tick(1'b1);  check_out("relock_edge3", 4'b1110);

        // Asynchronous reset while locked at cnt=2.
        tick(1'b0);  check_out("pre_rst_cnt1", 4'b1010);
        tick(1'b0);  check_out("pre_rst_cnt2", 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000);
        @(posedge iclk);
        #1;
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);  check_out("post_rst_edge", 4'b1101);
        tick(1'b1);  check_out("held_level", 4'b1000);

        // Ratio change 4 -> 2 at cnt=1: the running period finishes first.
        bus.div = 8'd1;
        tick(1'b0);  check_out("div1_cnt2", 4'b0000);
        tick(1'b0);  check_out("div1_cnt3", 4'b0000);
        tick(1'b0);  check_out("div1_wrap", 4'b1100);
        tick(1'b0);  check_out("div1_low", 4'b0000);
        tick(1'b0);  check_out("div1_high", 4'b1100);
        bus.div = 8'd0;
        tick(1'b0);  check_out("div0_low", 4'b0000);
        tick(1'b0);  check_out("div0_high", 4'b1100);
        tick(1'b0);  check_out("div0_low2", 4'b0000);
        tick(1'b0);  check_out("div0_high2", 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
